// File: rtl/spi_master_ext.sv
// spi_master_ext: SPI master with per-transfer mode bits (cpol, cpha, lsb_first),
// selectable active-low chip select and fixed lead/trail guard times.
// Optional feature macro: SPI_LOOPBACK_EN -- when defined, the receiver samples
// the internal mosi register instead of the miso port.
//
// state | meaning
// IDLE  | waiting for newd; sclk tracks the cpol input
// LEAD  | cs asserted, CLK_DIV cycles before the first sclk edge
// XFER  | 2*DATA_W sclk edges, one every CLK_DIV cycles
// TRAIL | CLK_DIV cycles after the last edge, then cs release and done
module spi_master_ext #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 10,
    parameter int NUM_CS  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      newd,
    input  logic [DATA_W-1:0]         din,
    input  logic [$clog2(NUM_CS)-1:0] cs_sel,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic                      lsb_first,
    input  logic                      miso,
    output logic                      sclk,
    output logic [NUM_CS-1:0]         cs,
    output logic                      mosi,
    output logic [DATA_W-1:0]         dout,
    output logic                      busy,
    output logic                      done
);

    localparam int CS_W   = $clog2(NUM_CS);
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [DATA_W-1:0]   tx_sr, rx_sr, din_ord, rx_ord;
    logic [NUM_CS-1:0]   cs_dec;
    logic                cpol_q, cpha_q, lsb_q;
    logic                tc, sclk_edge, last_edge, odd_edge;
    logic                sample_en, shift_en, rx_bit;

    assign tc        = (cnt == '0);
    assign sclk_edge = (state == XFER) && tc;
    assign last_edge = sclk_edge && (edge_cnt == EDGE_LAST);
    // edge_cnt holds the number of edges already generated, so the edge
    // about to happen is edge_cnt+1 and is odd when edge_cnt is even
    assign odd_edge  = ~edge_cnt[0];
    assign sample_en = sclk_edge && (cpha_q ? ~odd_edge : odd_edge);
    assign shift_en  = sclk_edge && (cpha_q ? odd_edge : (~odd_edge && ~last_edge));
    assign busy      = (state != IDLE);

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_bit      = mosi;
`else
    assign rx_bit      = miso;
`endif

    // Bit-reverse the transmit word for LSB-first so the shifter is always MSB-out
    always_comb begin
        din_ord = din;
        if (lsb_first)
            for (int i = 0; i < DATA_W; i++) din_ord[i] = din[DATA_W-1-i];
    end

    // Receiver always shifts in at the LSB; undo the order for LSB-first
    always_comb begin
        rx_ord = rx_sr;
        if (lsb_q)
            for (int i = 0; i < DATA_W; i++) rx_ord[i] = rx_sr[DATA_W-1-i];
    end

    // Out-of-range cs_sel matches no line, leaving every select deasserted
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (newd)      state_nxt = LEAD;
            LEAD:    if (tc)        state_nxt = XFER;
            XFER:    if (last_edge) state_nxt = TRAIL;
            TRAIL:   if (tc)        state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Timer, shifters, serial outputs and completion registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            edge_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            sclk     <= 1'b0;
            cs       <= '1;
            mosi     <= 1'b0;
            dout     <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (newd) begin
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        lsb_q    <= lsb_first;
                        cnt      <= CNT_LOAD;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        cs       <= cs_dec;
                        if (cpha) begin
                            tx_sr <= din_ord;
                            mosi  <= 1'b0;
                        end else begin
                            tx_sr <= {din_ord[DATA_W-2:0], 1'b0};
                            mosi  <= din_ord[DATA_W-1];
                        end
                    end
                end
                LEAD: begin
                    cnt <= tc ? CNT_LOAD : cnt - CNT_W'(1);
                end
                XFER: begin
                    cnt <= tc ? CNT_LOAD : cnt - CNT_W'(1);
                    if (sclk_edge) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                    end
                    if (sample_en) rx_sr <= {rx_sr[DATA_W-2:0], rx_bit};
                    if (shift_en) begin
                        mosi  <= tx_sr[DATA_W-1];
                        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                end
                TRAIL: begin
                    cnt <= tc ? CNT_LOAD : cnt - CNT_W'(1);
                    if (tc) begin
                        cs   <= '1;
                        dout <= rx_ord;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/spi_master_ext.md
SPI_MASTER_EXT -- requirements
Module: spi_master_ext

Interface
REQ-001 SHALL have parameter DATA_W, default 12: frame width in bits, legal 2..32.
REQ-002 SHALL have parameter CLK_DIV, default 10: clk cycles per sclk half-period, legal >=1.
REQ-003 SHALL have parameter NUM_CS, default 2: number of chip selects, legal 2..8.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port newd  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port din  input  DATA_W  transmit word, latched at start.
REQ-008 SHALL have port cs_sel  input  $clog2(NUM_CS)  target select, latched at start.
REQ-009 SHALL have ports cpol, cpha, lsb_first  input  1 each  mode bits, latched at start.
REQ-010 SHALL have port miso  input  1  serial receive data.
REQ-011 SHALL have port sclk  output  1  serial clock, registered.
REQ-012 SHALL have port cs  output  NUM_CS  active-low chip selects, registered.
REQ-013 SHALL have port mosi  output  1  serial transmit data, registered.
REQ-014 SHALL have port dout  output  DATA_W  last received word, held until next done.
REQ-015 SHALL have ports busy, done  output  1 each  transfer active; one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, LEAD, XFER, TRAIL.
REQ-017 SHALL, in IDLE with newd=1, latch din, cs_sel and mode bits, drive cs[cs_sel]=0, and enter LEAD next cycle.
REQ-018 SHALL hold LEAD for CLK_DIV cycles, then enter XFER.
REQ-019 SHALL generate 2*DATA_W sclk edges in XFER, one every CLK_DIV cycles, then enter TRAIL.
REQ-020 SHALL hold sclk at latched cpol outside XFER; in IDLE sclk follows the cpol input, registered.
REQ-021 SHALL, for cpha=0, present the first bit on mosi at cs assertion, sample miso on odd edges and shift mosi on even edges except the last.
REQ-022 SHALL, for cpha=1, shift mosi on odd edges (first bit on edge 1) and sample miso on even edges.
REQ-023 SHALL transmit and assemble received bits MSB-first when lsb_first=0, LSB-first when 1.
REQ-024 SHALL hold TRAIL for CLK_DIV cycles, then, in one cycle: return to IDLE, drive all cs=1, update dout, pulse done=1, drive busy=0.
REQ-025 SHALL produce done exactly 1+(2*DATA_W+2)*CLK_DIV cycles after the cycle newd is accepted.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL ignore newd and changes on din, cs_sel and mode bits outside IDLE.
REQ-028 SHALL accept newd in the cycle done is high (back-to-back), with no idle gap.
REQ-029 SHALL, when cs_sel>=NUM_CS, run the full transfer with all cs held at 1 and still pulse done.

Reset
REQ-030 SHALL, on rst=0 at any time including mid-transfer, immediately enter IDLE with sclk=0, cs=all ones, mosi=0, dout=0, busy=0, done=0.
REQ-031 SHALL produce no done pulse for a transfer aborted by reset.

Configuration
REQ-032 SHALL, when SPI_LOOPBACK_EN is defined, sample internal mosi instead of the miso port, so dout equals din after each transfer.
REQ-033 SHALL, when SPI_LOOPBACK_EN is undefined, sample the miso port only, with no loopback logic present.

Verification (DATA_W=12, CLK_DIV=2, NUM_CS=2)
REQ-034 SHALL cover mode 0, MSB-first: din=0xA5C, cs_sel=1, miso driven from slave model 0x3F0 -> cs=2'b01 during transfer; mosi bits 1010_0101_1100; dout=0x3F0; done at cycle 53.
REQ-035 SHALL cover mode 3 (cpol=1, cpha=1), lsb_first=1: din=0x001 -> sclk idles high; first mosi bit 1; dout matches slave word LSB-first.
REQ-036 SHALL cover back-to-back: newd held high for 2 transfers (0x123, 0x456) -> second LEAD begins the cycle after first done; 2 done pulses 53 cycles apart.
REQ-037 SHALL cover reset mid-XFER at cycle 20 -> cs=2'b11, sclk=0, busy=0 within same edge; no done; next transfer completes normally.
REQ-038 SHALL cover newd pulses and din=0xFFF changes during busy -> ignored; transmitted word unchanged.
REQ-039 SHALL cover, with SPI_LOOPBACK_EN defined, din=0x5A3 and miso tied 0 -> dout=0x5A3.
